csr_rmw_ctrl: RTL and testbench

- Initiator side of the CSR register-file port.
- Accepts one CSR access request at a time from the execute stage over a valid/ready handshake. Supported operations are read, write, set-bits and clear-bits.
- Drives the CSR file's combinational read port and synchronous write port to perform a read-modify-write, then returns the old CSR value over a second valid/ready handshake.
- Sits between the execute stage and the CSR register file (256 x 24-bit).

---
 rtl/csr_rmw_ctrl_pkg.sv | 24 ++
 rtl/csr_rmw_alu.sv | 35 +++
 rtl/csr_rmw_ctrl.sv | 144 ++++++++++++++
 tb/tb_csr_rmw_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/csr_rmw_ctrl_pkg.sv
// Shared sizes, op encodings and state type for the CSR read-modify-write initiator.
package csr_rmw_ctrl_pkg;

   localparam int unsigned CSR_AW  = 8;
   localparam int unsigned CSR_DW  = 24;
   localparam int unsigned CSR_OPW = 2;

   localparam logic [CSR_AW-1:0] CSR_RO_BASE = 8'hC0;

   typedef enum logic [CSR_OPW-1:0] {
      CSR_OP_READ  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational modify step: new CSR value and whether a write is needed at all.
module csr_rmw_alu
   import csr_rmw_ctrl_pkg::*;
#(
   parameter int unsigned DW = CSR_DW
) (
   input  logic [CSR_OPW-1:0] op,
   input  logic [DW-1:0]      old,
   input  logic [DW-1:0]      wdata,
   output logic [DW-1:0]      new_val,
   output logic               write_needed
);

   // Zero-mask SET/CLEAR leave the CSR untouched, so they skip the write.
   always_comb begin
      new_val      = old;
      write_needed = 1'b0;
      case (op)
         CSR_OP_WRITE: begin
            new_val      = wdata;
            write_needed = 1'b1;
         end
         CSR_OP_SET: begin
            new_val      = old | wdata;
            write_needed = |wdata;
         end
         CSR_OP_CLEAR: begin
            new_val      = old & ~wdata;
            write_needed = |wdata;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// CSR port initiator: accepts one request, does read-modify-write on the CSR file,
// then returns the pre-modification value.
module csr_rmw_ctrl
   import csr_rmw_ctrl_pkg::*;
#(
   parameter int unsigned    AW      = CSR_AW,
   parameter int unsigned    DW      = CSR_DW,
   parameter logic [AW-1:0]  RO_BASE = AW'(CSR_RO_BASE)
) (
   input  logic               iw_clk,
   input  logic               iw_rst_n,
   input  logic               iw_req_valid,
   output logic               ow_req_ready,
   input  logic [CSR_OPW-1:0] iw_req_op,
   input  logic [AW-1:0]      iw_req_addr,
   input  logic [DW-1:0]      iw_req_wdata,
   output logic               ow_rsp_valid,
   input  logic               iw_rsp_ready,
   output logic [DW-1:0]      ow_rsp_rdata,
   output logic               ow_rsp_err,
   output logic [AW-1:0]      ow_csr_raddr,
   input  logic [DW-1:0]      iw_csr_rdata,
   output logic [AW-1:0]      ow_csr_waddr,
   output logic [DW-1:0]      ow_csr_wdata,
   output logic               ow_csr_we
);

   state_e               state_q, state_d;
   logic [CSR_OPW-1:0]   op_q, op_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [DW-1:0]        wdata_q, wdata_d;
   logic [DW-1:0]        rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic                 req_ready_q, req_ready_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 we_q, we_d;
   logic [AW-1:0]        waddr_q, waddr_d;
   logic [DW-1:0]        cwdata_q, cwdata_d;

   logic [DW-1:0]        new_val;
   logic                 write_needed;
   logic                 ro_hit;

   csr_rmw_alu #(.DW(DW)) u_alu (
      .op           (op_q),
      .old          (iw_csr_rdata),
      .wdata        (wdata_q),
      .new_val      (new_val),
      .write_needed (write_needed)
   );

   assign ro_hit = write_needed && (addr_q >= RO_BASE);

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      req_ready_d = req_ready_q;
      rsp_valid_d = rsp_valid_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      cwdata_d    = cwdata_q;
      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (iw_req_valid && req_ready_q) begin
               op_d        = iw_req_op;
               addr_d      = iw_req_addr;
               wdata_d     = iw_req_wdata;
               req_ready_d = 1'b0;
               state_d     = ST_READ;
            end
         end
         ST_READ: begin
            rdata_d = iw_csr_rdata;
            err_d   = ro_hit;
            if (write_needed && !ro_hit) begin
               we_d     = 1'b1;
               waddr_d  = addr_q;
               cwdata_d = new_val;
               state_d  = ST_WRITE;
            end else begin
               rsp_valid_d = 1'b1;
               state_d     = ST_RESP;
            end
         end
         ST_WRITE: begin
            rsp_valid_d = 1'b1;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (iw_rsp_ready) begin
               rsp_valid_d = 1'b0;
               req_ready_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Reset drops any in-flight write enable immediately.
   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         state_q     <= ST_IDLE;
         op_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         cwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         cwdata_q    <= cwdata_d;
      end
   end

   assign ow_req_ready = req_ready_q;
   assign ow_rsp_valid = rsp_valid_q;
   assign ow_rsp_rdata = rdata_q;
   assign ow_rsp_err   = err_q;
   assign ow_csr_raddr = addr_q;
   assign ow_csr_waddr = waddr_q;
   assign ow_csr_wdata = cwdata_q;
   assign ow_csr_we    = we_q;

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// Bench for csr_rmw_ctrl: vector table through a scoreboard queue, plus hold and
// mid-write reset sequences against a behavioural 256x24 CSR file.
module tb_csr_rmw_ctrl;
   import csr_rmw_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_addr;
   logic [23:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [23:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  csr_raddr;
   logic [23:0] csr_rdata;
   logic [7:0]  csr_waddr;
   logic [23:0] csr_wdata;
   logic        csr_we;

   logic [23:0] mem [256] = '{default: 24'h0};

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [23:0] wdata;
      logic [23:0] rdata;
      logic        err;
      logic        we;
      logic [23:0] nval;
      int          lat;
   } vec_t;

   typedef struct {
      logic [7:0]  addr;
      logic [23:0] data;
   } wr_t;

   vec_t vecs[$];
   vec_t sb[$];
   wr_t  we_log[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   csr_rmw_ctrl dut (
      .iw_clk       (clk),
      .iw_rst_n     (rst_n),
      .iw_req_valid (req_valid),
      .ow_req_ready (req_ready),
      .iw_req_op    (req_op),
      .iw_req_addr  (req_addr),
      .iw_req_wdata (req_wdata),
      .ow_rsp_valid (rsp_valid),
      .iw_rsp_ready (rsp_ready),
      .ow_rsp_rdata (rsp_rdata),
      .ow_rsp_err   (rsp_err),
      .ow_csr_raddr (csr_raddr),
      .iw_csr_rdata (csr_rdata),
      .ow_csr_waddr (csr_waddr),
      .ow_csr_wdata (csr_wdata),
      .ow_csr_we    (csr_we)
   );

   // Behavioural CSR file: combinational read, synchronous write.
   assign csr_rdata = mem[csr_raddr];
   always @(posedge clk) begin
      if (csr_we) begin
         mem[csr_waddr] <= csr_wdata;
         we_log.push_back('{addr: csr_waddr, data: csr_wdata});
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] addr,
                               input logic [23:0] wdata, input logic [23:0] rdata,
                               input logic err, input logic we, input logic [23:0] nval,
                               input int lat);
      vec_t v;
      v.op = op; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.err = err; v.we = we; v.nval = nval; v.lat = lat;
      return v;
   endfunction

   task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [23:0] wdata);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_ready_wait", 32'(req_ready), 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_op    = 2'($urandom);
      req_addr  = 8'($urandom);
      req_wdata = 24'($urandom);
   endtask

   task automatic wait_rsp(output int lat);
      lat = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = i;
            break;
         end
      end
      if (lat == 0) check("rsp_timeout", 32'd0, 32'd1);
   endtask

   task automatic release_rsp();
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      @(negedge clk);
      check("post_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_req_ready", 32'(req_ready), 32'd1);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      vec_t e;
      int   lat;
      we_log.delete();
      sb.push_back(v);
      issue(v.op, v.addr, v.wdata);
      wait_rsp(lat);
      e = sb.pop_front();
      check({tag, "_lat"},   32'(lat), 32'(e.lat));
      check({tag, "_rdata"}, 32'(rsp_rdata), 32'(e.rdata));
      check({tag, "_err"},   32'(rsp_err), 32'(e.err));
      check({tag, "_raddr"}, 32'(csr_raddr), 32'(e.addr));
      release_rsp();
      check({tag, "_we_cnt"}, 32'(we_log.size()), e.we ? 32'd1 : 32'd0);
      if (e.we && we_log.size() == 1) begin
         check({tag, "_waddr"}, 32'(we_log[0].addr), 32'(e.addr));
         check({tag, "_wdata"}, 32'(we_log[0].data), 32'(e.nval));
      end
      check({tag, "_mem"}, 32'(mem[e.addr]), e.we ? 32'(e.nval) : 32'(e.rdata));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0;

      vecs.push_back(mk(CSR_OP_WRITE, 8'h10, 24'h123456, 24'h000000, 0, 1, 24'h123456, 3));
      vecs.push_back(mk(CSR_OP_READ,  8'h10, 24'h000000, 24'h123456, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_WRITE, 8'h20, 24'h00F0F0, 24'h000000, 0, 1, 24'h00F0F0, 3));
      vecs.push_back(mk(CSR_OP_SET,   8'h20, 24'h0F0000, 24'h00F0F0, 0, 1, 24'h0FF0F0, 3));
      vecs.push_back(mk(CSR_OP_CLEAR, 8'h20, 24'h0000F0, 24'h0FF0F0, 0, 1, 24'h0FF000, 3));
      vecs.push_back(mk(CSR_OP_SET,   8'h20, 24'h000000, 24'h0FF000, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_CLEAR, 8'hC5, 24'h000000, 24'h000000, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_WRITE, 8'hC5, 24'hFFFFFF, 24'h000000, 1, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_READ,  8'hC5, 24'hFFFFFF, 24'h000000, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_WRITE, 8'hBF, 24'hABCDEF, 24'h000000, 0, 1, 24'hABCDEF, 3));
      vecs.push_back(mk(CSR_OP_SET,   8'hC0, 24'h000001, 24'h000000, 1, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_READ,  8'hBF, 24'h000000, 24'hABCDEF, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_CLEAR, 8'h10, 24'hFFFFFF, 24'h123456, 0, 1, 24'h000000, 3));
      vecs.push_back(mk(CSR_OP_READ,  8'h10, 24'h000000, 24'h000000, 0, 0, 24'h000000, 2));
      vecs.push_back(mk(CSR_OP_WRITE, 8'h30, 24'h0A0A0A, 24'h000000, 0, 1, 24'h0A0A0A, 3));

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_we",        32'(csr_we),    32'd0);
      check("rst_outs", 32'({rsp_rdata, rsp_err, csr_raddr, csr_waddr, csr_wdata}), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Response back-pressure: outputs stay put and new requests are ignored.
      we_log.delete();
      issue(CSR_OP_READ, 8'hBF, 24'h0);
      wait_rsp(lat);
      check("hold_lat", 32'(lat), 32'd2);
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_op = CSR_OP_WRITE; req_addr = 8'h70; req_wdata = 24'($urandom);
         check("hold_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", 32'(rsp_rdata), 32'hABCDEF);
         check("hold_err",   32'(rsp_err),   32'd0);
         check("hold_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      release_rsp();
      check("hold_no_we", 32'(we_log.size()), 32'd0);
      check("hold_mem70", 32'(mem[8'h70]), 32'd0);

      // Reset while the write enable is up: the write must not land.
      issue(CSR_OP_WRITE, 8'h30, 24'h555555);
      @(negedge clk);
      @(negedge clk);
      check("mid_we_up",  32'(csr_we), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_we_drop",   32'(csr_we),    32'd0);
      check("mid_req_ready", 32'(req_ready), 32'd0);
      check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_outs", 32'({rsp_rdata, rsp_err, csr_raddr, csr_waddr, csr_wdata}), 32'd0);
      repeat (2) @(negedge clk);
      check("mid_mem30", 32'(mem[8'h30]), 32'h0A0A0A);
      rst_n = 1'b1;
      for (int i = 0; i < 5 && !req_ready; i++) @(negedge clk);
      check("mid_ready_after", 32'(req_ready), 32'd1);
      run_vec(mk(CSR_OP_READ, 8'h30, 24'h0, 24'h0A0A0A, 0, 0, 24'h0, 2), "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
